data_mem_ctrl: RTL and testbench

Parametrised successor to the single-cycle CPU data RAM. It is a word-organised data memory with RISC-V load/store sizing (LB/LH/LW/LBU/LHU/SB/SH/SW) and a req/ready handshake. Latency is configurable through wait states, which lets the CPU be exercised against slow memory. It flags misaligned, out-of-range and illegal-size accesses, and sits between the CPU memory port and the data store.

---
 rtl/data_mem_ctrl_pkg.sv | 32 +++
 rtl/data_mem_ctrl_lsu_align.sv | 70 +++++++
 rtl/data_mem_ctrl.sv | 118 +++++++++++
 tb/tb_data_mem_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared encodings for the data memory controller: RISC-V load/store size codes,
// controller FSM states, and the size/alignment legality helpers.
package data_mem_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic f3_illegal(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_illegal = 1'b0;
            default:                        f3_illegal = 1'b1;
        endcase
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3)
            F3_H, F3_HU: f3_misaligned = lane[0];
            F3_W:        f3_misaligned = (lane != 2'b00);
            default:     f3_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_lsu_align.sv
// Combinational lane logic: byte enables and replicated store data for stores,
// byte/half/word extraction with sign or zero extension for loads.
module lsu_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_word,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and half out of the stored word (little-endian)
    always_comb begin
        byte_s = 8'h00;
        case (lane)
            2'b00:   byte_s = rd_word[7:0];
            2'b01:   byte_s = rd_word[15:8];
            2'b10:   byte_s = rd_word[23:16];
            2'b11:   byte_s = rd_word[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = lane[1] ? rd_word[31:16] : rd_word[15:0];
    end

    // Store data is replicated across lanes so byte_en alone selects what lands
    always_comb begin
        byte_en = 4'b0000;
        wr_word = 32'h0000_0000;
        ld_data = 32'h0000_0000;
        case (funct3)
            F3_B: begin
                byte_en = 4'b0001 << lane;
                wr_word = {4{wr_data[7:0]}};
                ld_data = {{24{byte_s[7]}}, byte_s};
            end
            F3_BU: begin
                byte_en = 4'b0001 << lane;
                wr_word = {4{wr_data[7:0]}};
                ld_data = {24'h00_0000, byte_s};
            end
            F3_H: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wr_data[15:0]}};
                ld_data = {{16{half_s[15]}}, half_s};
            end
            F3_HU: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wr_data[15:0]}};
                ld_data = {16'h0000, half_s};
            end
            F3_W: begin
                byte_en = 4'b1111;
                wr_word = wr_data;
                ld_data = rd_word;
            end
            default: begin
                byte_en = 4'b0000;
                wr_word = 32'h0000_0000;
                ld_data = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with RISC-V load/store sizing, req/ready handshake,
// configurable wait states and fault reporting (range, alignment, size code).
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic        ready,
    output logic [31:0] rd_data,
    output logic        err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem_r [DEPTH_WORDS];
    state_e        state_r;
    logic [3:0]    cnt_r;
    logic          we_r;
    logic [2:0]    f3_r;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;

    logic [31:0]   offset_s;
    logic [AW-1:0] idx_s;
    logic          fault_s;
    logic          commit_s;
    logic [31:0]   word_s;
    logic [31:0]   merged_s;
    logic [3:0]    be_s;
    logic [31:0]   wword_s;
    logic [31:0]   ld_s;

    // Decode the latched address; addresses below BASE_ADDR wrap to a huge offset
    always_comb begin
        offset_s = addr_r - BASE_ADDR;
        idx_s    = offset_s[AW+1:2];
        fault_s  = (|offset_s[31:AW+2]) | f3_illegal(f3_r) | f3_misaligned(f3_r, addr_r[1:0]);
        word_s   = mem_r[idx_s];
        commit_s = (state_r == ST_DONE) && we_r && !fault_s && !reset;
        for (int i = 0; i < 4; i++) begin
            merged_s[8*i +: 8] = be_s[i] ? wword_s[8*i +: 8] : word_s[8*i +: 8];
        end
    end

    lsu_align u_lsu_align (
        .funct3  (f3_r),
        .lane    (addr_r[1:0]),
        .wr_data (wdata_r),
        .rd_word (word_s),
        .byte_en (be_s),
        .wr_word (wword_s),
        .ld_data (ld_s)
    );

    // Storage array: written only on the DONE edge, never cleared by reset
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_r[idx_s] <= merged_s;
        end
    end

    // Access FSM with registered completion outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            f3_r    <= 3'b000;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            ready   <= 1'b0;
            err     <= 1'b0;
            rd_data <= 32'h0000_0000;
        end else begin
            ready   <= 1'b0;
            err     <= 1'b0;
            rd_data <= 32'h0000_0000;
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        we_r    <= we;
                        f3_r    <= funct3;
                        addr_r  <= addr;
                        wdata_r <= wr_data;
                        cnt_r   <= 4'(WAIT_STATES);
                        state_r <= (WAIT_STATES > 0) ? ST_WAIT : ST_DONE;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r <= 4'd1) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ready   <= 1'b1;
                    err     <= fault_s;
                    rd_data <= (fault_s || we_r) ? 32'h0000_0000 : ld_s;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (0 and 3 wait states, different bases)
// checked against a byte-addressed reference model.
module tb_data_mem_ctrl;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_a  [2];
    logic        req_a  [2];
    logic        we_a   [2];
    logic [2:0]  f3_a   [2];
    logic [31:0] addr_a [2];
    logic [31:0] wd_a   [2];
    logic        rdy_a  [2];
    logic        err_a  [2];
    logic [31:0] rd_a   [2];

    int total = 0;
    int bad   = 0;
    logic [7:0] mb [2][4*DEPTH];

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE0), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
        .clk(clk), .reset(rst_a[0]), .req(req_a[0]), .we(we_a[0]), .funct3(f3_a[0]),
        .addr(addr_a[0]), .wr_data(wd_a[0]), .ready(rdy_a[0]), .rd_data(rd_a[0]), .err(err_a[0]));

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE1), .WAIT_STATES(3), .INIT_FILE("")) dut1 (
        .clk(clk), .reset(rst_a[1]), .req(req_a[1]), .we(we_a[1]), .funct3(f3_a[1]),
        .addr(addr_a[1]), .wr_data(wd_a[1]), .ready(rdy_a[1]), .rd_data(rd_a[1]), .err(err_a[1]));

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? BASE0 : BASE1;
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit is_fault(input int d, input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] off;
        int sz;
        off = a - base_of(d);
        sz  = size_of(f3);
        if (sz == 0) return 1'b1;
        if (off >= 32'(4*DEPTH)) return 1'b1;
        if ((a & 32'(sz-1)) != 32'h0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] off;
        logic [31:0] v;
        off = a - base_of(d);
        v = 32'h0;
        for (int i = 0; i < size_of(f3); i++) v[8*i +: 8] = mb[d][off+32'(i)];
        if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic model_store(input int d, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] off;
        off = a - base_of(d);
        for (int i = 0; i < size_of(f3); i++) mb[d][off+32'(i)] = wd[8*i +: 8];
    endtask

    // Drive one access from #1 after an edge; returns at #1 after the edge that raised ready
    task automatic access(input int d, input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input bit drop,
                          output logic [31:0] rd, output logic e, output int lat);
        req_a[d] = 1'b1; we_a[d] = w; f3_a[d] = f3; addr_a[d] = a; wd_a[d] = wd;
        @(posedge clk); #1;
        req_a[d] = !drop; we_a[d] = ~w; f3_a[d] = 3'($urandom);
        addr_a[d] = $urandom; wd_a[d] = $urandom;
        lat = -1; rd = 32'h0; e = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (rdy_a[d]) begin
                lat = k; rd = rd_a[d]; e = err_a[d];
                break;
            end
        end
        req_a[d] = 1'b0;
    endtask

    task automatic test_reset();
        int pulses;
        for (int d = 0; d < 2; d++) begin
            rst_a[d] = 1'b1; req_a[d] = 1'b1; we_a[d] = 1'b0; f3_a[d] = 3'b010;
            addr_a[d] = base_of(d); wd_a[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            rst_a[d] = 1'b0; req_a[d] = 1'b0;
            total++;
            if (rdy_a[d] !== 1'b0 || err_a[d] !== 1'b0 || rd_a[d] !== 32'h0) begin
                bad++;
                $display("FAIL reset_state d%0d: got ready=%b err=%b rd=%h want 0 0 0", d, rdy_a[d], err_a[d], rd_a[d]);
            end
        end
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rdy_a[0] || rdy_a[1]) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL reset_req_ignored: got %0d ready pulses want 0", pulses);
        end
    endtask

    task automatic fill_memory();
        logic [31:0] rd, wd;
        logic e;
        int lat;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) begin
                wd = $urandom;
                access(d, 1'b1, 3'b010, base_of(d) + 32'(4*i), wd, 1'b0, rd, e, lat);
                model_store(d, 3'b010, base_of(d) + 32'(4*i), wd);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        logic e;
        int lat;
        access(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, rd, e, lat);
        model_store(0, 3'b010, 32'h10, 32'hDEADBEEF);
        total++;
        if (lat !== 1 || e !== 1'b0) begin
            bad++; $display("FAIL sw_basic: got lat=%0d err=%b want lat=1 err=0", lat, e);
        end
        access(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, e, lat);
        total++;
        if (lat !== 1 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
            bad++; $display("FAIL lw_basic: got lat=%0d err=%b rd=%h want 1 0 deadbeef", lat, e, rd);
        end
    endtask

    task automatic test_sub_word();
        logic [31:0] rd;
        logic e;
        int lat;
        logic [2:0]  f3s [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] as  [5] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h12};
        logic [31:0] exp [5] = '{32'hDEAD12EF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD};
        access(0, 1'b1, 3'b000, 32'h11, 32'hFFFF_FF12, 1'b0, rd, e, lat);
        model_store(0, 3'b000, 32'h11, 32'hFFFF_FF12);
        for (int i = 0; i < 5; i++) begin
            access(0, 1'b0, f3s[i], as[i], 32'h0, 1'b0, rd, e, lat);
            total++;
            if (rd !== exp[i] || e !== 1'b0) begin
                bad++; $display("FAIL subword_load%0d: got rd=%h err=%b want %h 0", i, rd, e, exp[i]);
            end
        end
        access(0, 1'b1, 3'b001, 32'h12, 32'h1234_BEEF, 1'b0, rd, e, lat);
        model_store(0, 3'b001, 32'h12, 32'h1234_BEEF);
        access(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, e, lat);
        total++;
        if (rd !== 32'hBEEF12EF) begin
            bad++; $display("FAIL sh_merge: got %h want beef12ef", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, rd2;
        logic e, e2;
        int lat, lat2;
        time t0, t1, t2;
        for (int d = 0; d < 2; d++) begin
            t0 = $time;
            access(d, 1'b0, 3'b010, base_of(d) + 32'h10, 32'h0, 1'b0, rd, e, lat);
            t1 = $time;
            access(d, 1'b0, 3'b010, base_of(d) + 32'h14, 32'h0, 1'b0, rd2, e2, lat2);
            t2 = $time;
            total++;
            if (lat !== (d == 0 ? 1 : 4) || rd !== model_load(d, 3'b010, base_of(d) + 32'h10)) begin
                bad++; $display("FAIL latency d%0d: got lat=%0d rd=%h want lat=%0d", d, lat, rd, d == 0 ? 1 : 4);
            end
            total++;
            if ((t2 - t1) !== (t1 - t0) || (t1 - t0) !== time'(d == 0 ? 20 : 50)
                || rd2 !== model_load(d, 3'b010, base_of(d) + 32'h14)) begin
                bad++; $display("FAIL b2b_spacing d%0d: got %0t/%0t rd=%h want %0d", d, t1 - t0, t2 - t1, rd2, d == 0 ? 20 : 50);
            end
        end
    endtask

    task automatic test_faults();
        logic [31:0] rd;
        logic e;
        int lat;
        int          ds  [5] = '{0, 0, 0, 0, 1};
        logic        ws  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [2:0]  f3s [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b010};
        logic [31:0] as  [5] = '{32'h12, 32'h11, 32'h100, 32'h10, 32'h0FFC};
        for (int i = 0; i < 5; i++) begin
            access(ds[i], ws[i], f3s[i], as[i], 32'hA5A5_5A5A, 1'b0, rd, e, lat);
            total++;
            if (e !== 1'b1 || rd !== 32'h0 || lat !== (ds[i] == 0 ? 1 : 4)) begin
                bad++; $display("FAIL fault%0d: got err=%b rd=%h lat=%0d want err=1 rd=0", i, e, rd, lat);
            end
            access(ds[i], 1'b0, 3'b010, base_of(ds[i]) + 32'h10, 32'h0, 1'b0, rd, e, lat);
            total++;
            if (rd !== model_load(ds[i], 3'b010, base_of(ds[i]) + 32'h10) || e !== 1'b0) begin
                bad++; $display("FAIL fault%0d_nowrite: got %h want %h", i, rd, model_load(ds[i], 3'b010, base_of(ds[i]) + 32'h10));
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        logic e;
        int lat, pulses;
        req_a[1] = 1'b1; we_a[1] = 1'b1; f3_a[1] = 3'b010; addr_a[1] = BASE1 + 32'h20; wd_a[1] = 32'h1;
        @(posedge clk); #1;
        req_a[1] = 1'b0;
        @(posedge clk); #1;
        rst_a[1] = 1'b1;
        @(posedge clk); #1;
        rst_a[1] = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rdy_a[1]) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++; $display("FAIL abort_no_ready: got %0d pulses want 0", pulses);
        end
        access(1, 1'b0, 3'b010, BASE1 + 32'h20, 32'h0, 1'b0, rd, e, lat);
        total++;
        if (rd !== model_load(1, 3'b010, BASE1 + 32'h20)) begin
            bad++; $display("FAIL abort_no_commit: got %h want %h", rd, model_load(1, 3'b010, BASE1 + 32'h20));
        end
    endtask

    task automatic test_req_drop();
        logic [31:0] rd;
        logic e;
        int lat, pulses;
        access(1, 1'b0, 3'b010, BASE1 + 32'h10, 32'h0, 1'b1, rd, e, lat);
        total++;
        if (lat !== 4 || rd !== model_load(1, 3'b010, BASE1 + 32'h10) || e !== 1'b0) begin
            bad++; $display("FAIL req_drop: got lat=%0d rd=%h err=%b want lat=4", lat, rd, e);
        end
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (rdy_a[1]) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++; $display("FAIL req_drop_single: got %0d extra pulses want 0", pulses);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, wd, exp_rd;
        logic e, w;
        logic [2:0] f3;
        int lat;
        bit flt;
        for (int n = 0; n < 300; n++) begin
            int d;
            d  = n % 2;
            w  = 1'($urandom);
            f3 = 3'($urandom);
            wd = $urandom;
            if ($urandom_range(0, 9) == 0) a = base_of(d) - 32'($urandom_range(1, 8));
            else a = base_of(d) + 32'($urandom_range(0, 4*DEPTH + 15));
            flt = is_fault(d, f3, a);
            exp_rd = (flt || w) ? 32'h0 : model_load(d, f3, a);
            access(d, w, f3, a, wd, 1'b0, rd, e, lat);
            if (!flt && w) model_store(d, f3, a, wd);
            total++;
            if (rd !== exp_rd || e !== flt || lat !== (d == 0 ? 1 : 4)) begin
                bad++;
                $display("FAIL random%0d: d%0d we=%b f3=%b a=%h got rd=%h err=%b lat=%0d want rd=%h err=%b",
                         n, d, w, f3, a, rd, e, lat, exp_rd, flt);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_a[d] = 1'b1; req_a[d] = 1'b0; we_a[d] = 1'b0; f3_a[d] = 3'b000;
            addr_a[d] = 32'h0; wd_a[d] = 32'h0;
        end
        @(posedge clk); #1;
        test_reset();
        fill_memory();
        test_basic();
        test_sub_word();
        test_back_to_back();
        test_faults();
        test_reset_abort();
        test_req_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
